hold_1_mon: RTL

Receive-side monitor for the two held outputs (g, f) of the hold_1 state machine. It measures every high run ("hold") on each line in clock cycles. Each completed hold becomes a {line id, length} record, delivered through a small FIFO on a valid/ready stream. It sits beside hold_1 in the example design and gives benches and downstream logic a cycle-exact account of the hold behaviour.

---
 rtl/hold_1_mon_pkg.sv | 10 +
 rtl/hold_1_rec_fifo.sv | 40 ++++
 rtl/hold_1_mon.sv | 69 ++++++
 3 files changed

// File: rtl/hold_1_mon_pkg.sv
// hold_1_mon_pkg: shared line ids and the hold record layout for hold_1_mon.
package hold_1_mon_pkg;
  localparam int REC_CNT_W = 8;
  localparam logic ID_G = 1'b0;
  localparam logic ID_F = 1'b1;
  typedef struct packed {
    logic                 id;
    logic [REC_CNT_W-1:0] len;
  } rec_t;
endpackage

// File: rtl/hold_1_rec_fifo.sv
// hold_1_rec_fifo: synchronous show-ahead FIFO for hold records.
// Ports: clk, rst (async, active-high); push/din write; pop advances the
// head; head shows the oldest entry (zero when empty); full/empty flags.
// A pop at full frees the slot for a push in the same cycle.
module hold_1_rec_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_pop, do_push;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_push);
      rp  <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/hold_1_mon.sv
// hold_1_mon: measures high runs on lines g and f and streams {id, len} records.
// Ports: clk, rst (async, active-high); g, f held lines; rec_valid/rec_ready
// stream handshake with rec_id (0 = g, 1 = f) and rec_len; ovf sticky drop
// flag cleared by ovf_clr (a same-cycle drop wins).
module hold_1_mon
  import hold_1_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g,
  input  logic             f,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_id,
  output logic [CNT_W-1:0] rec_len,
  output logic             ovf,
  input  logic             ovf_clr
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt_g, cnt_f, len_g, len_f;
  logic             pend_v_g, pend_v_f;
  logic             cap_g, cap_f, push_g, push_f, drop_g, drop_f;
  logic             space, full, empty, pop;
  logic [CNT_W:0]   din, head;
  // A run ends on the first low sample after a nonzero count.
  assign cap_g  = !g && cnt_g != '0;
  assign cap_f  = !f && cnt_f != '0;
  // A same-cycle pop makes room even when the FIFO is full.
  assign space  = !full || pop;
  assign push_g = pend_v_g && space;
  assign push_f = pend_v_f && space && !pend_v_g;
  assign drop_g = cap_g && pend_v_g && !push_g;
  assign drop_f = cap_f && pend_v_f && !push_f;
  assign din    = push_g ? {ID_G, len_g} : {ID_F, len_f};
  assign rec_valid = !empty;
  assign pop       = rec_valid && rec_ready;
  assign {rec_id, rec_len} = head;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_g    <= '0;
      cnt_f    <= '0;
      len_g    <= '0;
      len_f    <= '0;
      pend_v_g <= 1'b0;
      pend_v_f <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      cnt_g    <= g ? (cnt_g == MAX ? cnt_g : cnt_g + 1'b1) : '0;
      cnt_f    <= f ? (cnt_f == MAX ? cnt_f : cnt_f + 1'b1) : '0;
      if (cap_g && !drop_g) len_g <= cnt_g;
      if (cap_f && !drop_f) len_f <= cnt_f;
      pend_v_g <= cap_g || (pend_v_g && !push_g);
      pend_v_f <= cap_f || (pend_v_f && !push_f);
      ovf      <= drop_g || drop_f || (ovf && !ovf_clr);
    end
  hold_1_rec_fifo #(.W(CNT_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_g || push_f),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
endmodule
